// File: rtl/mem_axi4_master_bridge_pkg.sv
// Shared state type and AXI4 constants for the simple load/store port to AXI4 master bridge.
// Response codes live here so the bridge and the peripheral models agree on one definition.
package mem_axi4_master_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_RDADDR = 3'd2,
    ST_RDDATA = 3'd3,
    ST_DONE   = 3'd4
  } bridge_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // SLVERR and DECERR both set bit 1; EXOKAY counts as success.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/mem_axi4_master_bridge.sv
// Single-outstanding load/store port to single-beat AXI4 master bridge.
// Valids are held until handshake; bready/rready stay high while a response is pending.
module mem_axi4_master_bridge
  import mem_axi4_master_bridge_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] ERR_RDATA = '0
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [3:0]        mem_wstrb_i,
  output logic              mem_accept_o,
  output logic              mem_ack_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_error_o,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  bridge_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              is_write_q, is_write_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              b_done_q, b_done_d;
  logic [1:0]        resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic unused_rlast;
  assign unused_rlast = rlast;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    is_write_d = is_write_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    b_done_d   = b_done_q;
    resp_d     = resp_q;
    rdata_d    = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_req_i) begin
          addr_d     = mem_addr_i;
          wdata_d    = mem_wdata_i;
          wstrb_d    = mem_wstrb_i;
          is_write_d = mem_we_i;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          b_done_d   = 1'b0;
          resp_d     = AXI_RESP_OKAY;
          rdata_d    = '0;
          if (mem_we_i) begin
            state_d   = ST_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
          end else begin
            state_d   = ST_RDADDR;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
          end
        end
      end

      // AW, W and B complete in any order; B may even beat AW.
      ST_WRITE: begin
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (bvalid && bready_q && !b_done_q) begin
          b_done_d = 1'b1;
          resp_d   = bresp;
        end
        if (aw_done_d && w_done_d && b_done_d) begin
          bready_d = 1'b0;
          state_d  = ST_DONE;
        end
      end

      ST_RDADDR: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          if (rvalid && rready_q) begin
            rdata_d  = rdata;
            resp_d   = rresp;
            rready_d = 1'b0;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_RDDATA;
          end
        end
      end

      ST_RDDATA: begin
        if (rvalid && rready_q) begin
          rdata_d  = rdata;
          resp_d   = rresp;
          rready_d = 1'b0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      is_write_q <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
      resp_q     <= AXI_RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      is_write_q <= is_write_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      b_done_q   <= b_done_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign mem_accept_o = (state_q == ST_IDLE);
  assign mem_ack_o    = (state_q == ST_DONE);
  assign mem_error_o  = mem_ack_o && resp_is_error(resp_q);

  // Writes and idle cycles present zero; failed reads present the configured error word.
  always_comb begin
    mem_rdata_o = '0;
    if (mem_ack_o && !is_write_q) begin
      mem_rdata_o = resp_is_error(resp_q) ? ERR_RDATA : rdata_q;
    end
  end

  assign awaddr  = addr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = AXI_SIZE_WORD;
  assign awburst = AXI_BURST_INCR;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;
  assign araddr  = addr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

endmodule

// File: tb/tb_mem_axi4_master_bridge.sv
// Scoreboard bench: randomized requests against a word-memory reference model and a
// model AXI slave with random readies, delayed responses and a same-cycle fast mode.
module tb_mem_axi4_master_bridge;
  import mem_axi4_master_bridge_pkg::*;

  localparam logic [31:0] ERR_VAL = 32'hBAD0_0BAD;

  logic        aclk = 1'b0;
  logic        areset;
  logic        mem_req_i, mem_we_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic        mem_accept_o, mem_ack_o, mem_error_o;
  logic [31:0] mem_rdata_o;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  mem_axi4_master_bridge #(.ADDR_W(32), .DATA_W(32), .ERR_RDATA(ERR_VAL)) dut (
    .aclk(aclk), .areset(areset),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
    .mem_accept_o(mem_accept_o), .mem_ack_o(mem_ack_o),
    .mem_rdata_o(mem_rdata_o), .mem_error_o(mem_error_o),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int failures = 0;
  int ack_count = 0;
  int exp_acks = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int last_ack_cyc = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t expq[$];

  logic [31:0] ref_mem [0:255];
  logic [31:0] smem [0:255];
  logic        fast;
  int          rdy_mode;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Address map of the model bus: region nibble [15:12] selects the response code.
  function automatic logic [1:0] region_resp(input logic [31:0] a);
    case (a[15:12])
      4'hF:    return AXI_RESP_DECERR;
      4'hE:    return AXI_RESP_SLVERR;
      4'hD:    return AXI_RESP_EXOKAY;
      default: return AXI_RESP_OKAY;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] slave_rdata(input logic [31:0] a);
    logic [1:0] r;
    r = region_resp(a);
    return r[1] ? 32'hDEAD_BEEF : smem[a[9:2]];
  endfunction

  function automatic logic next_rdy();
    if (rdy_mode == 1) return 1'b1;
    if (rdy_mode == 2) return 1'b0;
    return 1'($urandom_range(1, 0));
  endfunction

  // Model slave
  logic        aw_rdy_q, w_rdy_q, ar_rdy_q;
  logic        have_aw, have_w, b_issued, have_ar;
  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q, tmp_resp;
  logic [31:0] s_awaddr, s_wdata, s_araddr, rdata_q;
  logic [3:0]  s_wstrb;

  always @(posedge aclk) begin
    if (areset) begin
      aw_rdy_q <= 1'b0; w_rdy_q <= 1'b0; ar_rdy_q <= 1'b0;
      have_aw <= 1'b0; have_w <= 1'b0; b_issued <= 1'b0; have_ar <= 1'b0;
      bvalid_q <= 1'b0; rvalid_q <= 1'b0; bresp_q <= 2'b00; rresp_q <= 2'b00;
      s_awaddr <= '0; s_wdata <= '0; s_araddr <= '0; s_wstrb <= '0; rdata_q <= '0;
      for (int i = 0; i < 256; i++) smem[i] <= '0;
    end else begin
      aw_rdy_q <= fast ? ((have_w || (wvalid && wready)) && !have_aw) : next_rdy();
      w_rdy_q  <= fast ? 1'b1 : next_rdy();
      ar_rdy_q <= next_rdy();
      if (awvalid && awready) begin
        have_aw  <= 1'b1;
        s_awaddr <= awaddr;
      end
      if (wvalid && wready) begin
        have_w  <= 1'b1;
        s_wdata <= wdata;
        s_wstrb <= wstrb;
        if (fast) begin
          b_issued <= 1'b1;
          tmp_resp = region_resp(awaddr);
          if (!tmp_resp[1]) smem[awaddr[9:2]] <= merge_bytes(smem[awaddr[9:2]], wdata, wstrb);
        end
      end
      if (!fast && have_aw && have_w && !b_issued && rdy_mode != 2 && $urandom_range(1, 0) == 1) begin
        tmp_resp = region_resp(s_awaddr);
        if (!tmp_resp[1]) smem[s_awaddr[9:2]] <= merge_bytes(smem[s_awaddr[9:2]], s_wdata, s_wstrb);
        bvalid_q <= 1'b1;
        bresp_q  <= tmp_resp;
        b_issued <= 1'b1;
      end
      if (bvalid_q && bready) bvalid_q <= 1'b0;
      if (have_aw && have_w && b_issued && !bvalid_q) begin
        have_aw <= 1'b0; have_w <= 1'b0; b_issued <= 1'b0;
      end
      if (!fast) begin
        if (arvalid && arready) begin
          have_ar  <= 1'b1;
          s_araddr <= araddr;
        end
        if (have_ar && !rvalid_q && rdy_mode != 2 && $urandom_range(1, 0) == 1) begin
          rvalid_q <= 1'b1;
          rdata_q  <= slave_rdata(s_araddr);
          rresp_q  <= region_resp(s_araddr);
        end
        if (rvalid_q && rready) begin
          rvalid_q <= 1'b0;
          have_ar  <= 1'b0;
        end
      end
    end
  end

  assign awready = aw_rdy_q;
  assign wready  = w_rdy_q;
  assign arready = ar_rdy_q;
  assign bvalid  = fast ? (wvalid && wready && !have_w) : bvalid_q;
  assign bresp   = fast ? region_resp(awaddr) : bresp_q;
  assign rvalid  = fast ? (arvalid && arready) : rvalid_q;
  assign rdata   = fast ? slave_rdata(araddr) : rdata_q;
  assign rresp   = fast ? region_resp(araddr) : rresp_q;
  assign rlast   = rvalid;

  // Monitor: every ack pops one expectation.
  always @(negedge aclk) begin
    if (!areset && mem_ack_o) begin
      ack_count++;
      last_ack_cyc = cyc;
      if (expq.size() == 0) begin
        check_output("unexpected_ack", 32'(mem_ack_o), 32'h0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check_output(e.we ? "write_rdata" : "read_rdata", mem_rdata_o, e.rdata);
        check_output(e.we ? "write_error" : "read_error", 32'(mem_error_o), 32'(e.err));
      end
    end
  end

  // Protocol watcher: valids and payloads hold until handshake; readies cover responses.
  logic        p_aw, p_w, p_ar;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;
  initial begin p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0; end

  always @(negedge aclk) begin
    if (!areset) begin
      if (p_aw) begin
        check_output("awvalid_hold", 32'(awvalid), 32'h1);
        check_output("awaddr_stable", awaddr, p_awaddr);
      end
      if (p_w) begin
        check_output("wvalid_hold", 32'(wvalid), 32'h1);
        check_output("wdata_stable", wdata, p_wdata);
        check_output("wstrb_stable", 32'(wstrb), 32'(p_wstrb));
      end
      if (p_ar) begin
        check_output("arvalid_hold", 32'(arvalid), 32'h1);
        check_output("araddr_stable", araddr, p_araddr);
      end
      if (awvalid) check_output("aw_attrs", {19'd0, awlen, awsize, awburst}, {19'd0, 8'd0, 3'b010, 2'b01});
      if (arvalid) check_output("ar_attrs", {19'd0, arlen, arsize, arburst}, {19'd0, 8'd0, 3'b010, 2'b01});
      if (wvalid)  check_output("wlast", 32'(wlast), 32'h1);
      if (bvalid)  check_output("bready_on_bvalid", 32'(bready), 32'h1);
      if (rvalid)  check_output("rready_on_rvalid", 32'(rready), 32'h1);
    end
    p_aw = !areset && awvalid && !awready;
    p_w  = !areset && wvalid && !wready;
    p_ar = !areset && arvalid && !arready;
    p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb; p_araddr = araddr;
  end

  // Reference model: the memory is updated when the request is issued.
  task automatic push_expect(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] st);
    exp_t       e;
    logic [1:0] r;
    r = region_resp(addr);
    e.we = we; e.addr = addr; e.err = r[1];
    if (we) begin
      e.rdata = 32'h0;
      if (!r[1]) ref_mem[addr[9:2]] = merge_bytes(ref_mem[addr[9:2]], wd, st);
    end else begin
      e.rdata = r[1] ? ERR_VAL : ref_mem[addr[9:2]];
    end
    expq.push_back(e);
    exp_acks++;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] st);
    mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wd; mem_wstrb_i = st;
  endtask

  task automatic wait_accept(output logic ok);
    int n;
    n = 0;
    @(negedge aclk);
    while (!mem_accept_o && n < 300) begin
      @(negedge aclk);
      n++;
    end
    ok = mem_accept_o;
    if (!ok) check_output("accept_timeout", 32'(mem_accept_o), 32'h1);
  endtask

  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [3:0] st);
    logic ok;
    wait_accept(ok);
    if (ok) begin
      drive_req(we, addr, wd, st);
      push_expect(we, addr, wd, st);
      issue_cyc = cyc;
      @(posedge aclk);
      #1 mem_req_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 400) begin
      @(negedge aclk);
      n++;
    end
    if (expq.size() != 0) begin
      check_output("ack_timeout", 32'(expq.size()), 32'h0);
      exp_acks -= expq.size();
      expq.delete();
    end
    @(negedge aclk);
  endtask

  task automatic set_mode(input logic f, input int m);
    fast = f;
    rdy_mode = m;
    repeat (2) @(negedge aclk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [3:0] region;
    case ($urandom_range(7, 0))
      4: region = 4'hC;
      5: region = 4'hD;
      6: region = 4'hE;
      7: region = 4'hF;
      default: region = 4'h0;
    endcase
    return {16'h0200, region, 2'b00, 4'h0, 4'($urandom_range(15, 0)), 2'b00};
  endfunction

  initial begin
    logic ok;
    logic prev_ack;
    int   acks_before, n;
    logic [31:0] a;

    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    fast = 1'b0; rdy_mode = 0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check_output("reset_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'h0);
    check_output("reset_accept", 32'(mem_accept_o), 32'h1);
    check_output("reset_ack_err", {30'd0, mem_ack_o, mem_error_o}, 32'h0);
    check_output("reset_rdata", mem_rdata_o, 32'h0);
    check_output("reset_addr_data", awaddr | wdata | araddr, 32'h0);

    $display("[TB] directed write/read sequence");
    apply_stimulus(1'b1, 32'h0200_0000, 32'h1, 4'hF);
    wait_idle();
    apply_stimulus(1'b0, 32'h0200_0000, 32'h0, 4'h0);
    wait_idle();
    apply_stimulus(1'b0, 32'h0200_C004, 32'h0, 4'h0);
    wait_idle();

    $display("[TB] early B response before AW");
    set_mode(1'b1, 0);
    apply_stimulus(1'b1, 32'h0200_0014, 32'hA5A5_1234, 4'hF);
    wait_idle();
    set_mode(1'b0, 0);
    apply_stimulus(1'b0, 32'h0200_0014, 32'h0, 4'h0);
    wait_idle();

    $display("[TB] error responses");
    apply_stimulus(1'b0, 32'h0200_E008, 32'h0, 4'h0);
    wait_idle();
    apply_stimulus(1'b1, 32'h0200_F00C, 32'h1111_2222, 4'hF);
    wait_idle();

    $display("[TB] minimum latency read");
    set_mode(1'b1, 1);
    apply_stimulus(1'b0, 32'h0200_0000, 32'h0, 4'h0);
    wait_idle();
    check_output("min_latency", 32'(last_ack_cyc - issue_cyc), 32'd2);
    set_mode(1'b0, 0);

    $display("[TB] reset during write");
    set_mode(1'b0, 2);
    acks_before = ack_count;
    wait_accept(ok);
    if (ok) begin
      drive_req(1'b1, 32'h0200_0020, 32'hFFFF_FFFF, 4'hF);
      @(posedge aclk);
      #1 mem_req_i = 1'b0;
      @(negedge aclk);
      check_output("pre_reset_awvalid", 32'(awvalid), 32'h1);
      @(posedge aclk);
      #1 areset = 1'b1;
      @(posedge aclk);
      #1 areset = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      @(negedge aclk);
      check_output("post_reset_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'h0);
      check_output("post_reset_ack", 32'(mem_ack_o), 32'h0);
      check_output("post_reset_accept", 32'(mem_accept_o), 32'h1);
      repeat (3) @(negedge aclk);
      check_output("reset_no_ack", 32'(ack_count - acks_before), 32'h0);
    end
    set_mode(1'b0, 0);

    $display("[TB] request held high through a write");
    acks_before = ack_count;
    wait_accept(ok);
    if (ok) begin
      drive_req(1'b1, 32'h0200_0030, 32'hCAFE_F00D, 4'b0101);
      push_expect(1'b1, 32'h0200_0030, 32'hCAFE_F00D, 4'b0101);
      @(posedge aclk);
      #1 drive_req(1'b0, 32'h0200_0030, 32'h0, 4'h0);
      prev_ack = 1'b0;
      n = 0;
      @(negedge aclk);
      while (!mem_accept_o && n < 300) begin
        prev_ack = mem_ack_o;
        @(negedge aclk);
        n++;
      end
      check_output("held_req_after_done", {30'd0, mem_accept_o, prev_ack}, 32'h3);
      push_expect(1'b0, 32'h0200_0030, 32'h0, 4'h0);
      @(posedge aclk);
      #1 mem_req_i = 1'b0;
      wait_idle();
      repeat (3) @(negedge aclk);
      check_output("held_req_ack_count", 32'(ack_count - acks_before), 32'd2);
    end

    $display("[TB] randomized traffic");
    for (int t = 0; t < 160; t++) begin
      wait_idle();
      set_mode(1'($urandom_range(2, 0) == 0), int'($urandom_range(1, 0)));
      a = rand_addr();
      apply_stimulus(1'($urandom_range(1, 0)), a, $urandom, 4'($urandom_range(15, 0)));
    end
    wait_idle();
    repeat (4) @(negedge aclk);
    check_output("total_acks", 32'(ack_count), 32'(exp_acks));
    check_output("queue_empty", 32'(expq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
